// File: rtl/jpeg_pkg.sv
// Shared JPEG pipeline types and constants: block geometry, coefficient type
// and the zig-zag scan table (raster index for each zig-zag position).
package jpeg_pkg;

  localparam int unsigned BLK_SIZE = 64;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned COEFF_W  = 8;

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(BLK_SIZE - 1);

  typedef logic signed [COEFF_W-1:0] coeff_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_GAP
  } rd_state_e;

  localparam logic [CNT_W-1:0] ZZ_LUT [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zz_rd_ctrl.sv
// Read side of the zig-zag reorder: walks a full bank in zig-zag order and
// frames the 64-beat burst with first/last/block-enable.
module zz_rd_ctrl
  import jpeg_pkg::*;
#(
  parameter int unsigned W = COEFF_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       full,
  input  logic [W-1:0]     rd_data,
  output logic             rd_bank,
  output logic [CNT_W-1:0] rd_addr_c,
  output logic             rd_done_c,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic             out_first,
  output logic             out_last,
  output logic             out_blk_en
);

  rd_state_e        state_q, state_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             bank_d;
  logic             valid_d, first_d, last_d, blk_en_d;
  logic [W-1:0]     data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RD_IDLE;
      rd_cnt_q   <= '0;
      rd_bank    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      out_blk_en <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_bank    <= bank_d;
      out_valid  <= valid_d;
      out_data   <= data_d;
      out_first  <= first_d;
      out_last   <= last_d;
      out_blk_en <= blk_en_d;
    end
  end

  // The GAP cycle doubles as the start check so bursts repeat every 65 cycles.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    bank_d    = rd_bank;
    valid_d   = out_valid;
    data_d    = out_data;
    first_d   = out_first;
    last_d    = out_last;
    blk_en_d  = out_blk_en;
    rd_addr_c = ZZ_LUT[rd_cnt_q];
    rd_done_c = 1'b0;

    unique case (state_q)
      RD_IDLE, RD_GAP: begin
        rd_addr_c = ZZ_LUT[0];
        if (full[rd_bank]) begin
          data_d   = rd_data;
          valid_d  = 1'b1;
          first_d  = 1'b1;
          last_d   = 1'b0;
          blk_en_d = 1'b1;
          rd_cnt_d = CNT_W'(1);
          state_d  = RD_READ;
        end else begin
          state_d = RD_IDLE;
        end
      end
      RD_READ: begin
        if (out_valid && out_ready) begin
          if (out_last) begin
            rd_done_c = 1'b1;
            bank_d    = ~rd_bank;
            valid_d   = 1'b0;
            first_d   = 1'b0;
            last_d    = 1'b0;
            blk_en_d  = 1'b0;
            state_d   = RD_GAP;
          end else begin
            data_d   = rd_data;
            first_d  = 1'b0;
            last_d   = (rd_cnt_q == LAST_POS);
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

endmodule

// File: rtl/zigzag_reorder.sv
// Ping-pong coefficient buffer: fills one bank in raster order while the
// other bank is replayed in zig-zag order to the run-length encoder.
module zigzag_reorder
  import jpeg_pkg::*;
#(
  parameter int unsigned W = COEFF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         out_first,
  output logic         out_last,
  output logic         out_blk_en
);

  logic [W-1:0]     bank_mem [2][BLK_SIZE];
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             wb_q, wb_d;
  logic [1:0]       full_q, full_d;
  logic             in_ready_d;
  logic             wr_en_c;
  logic             rd_bank;
  logic [CNT_W-1:0] rd_addr_c;
  logic             rd_done_c;
  logic [W-1:0]     rd_data_c;

  // Write-side bookkeeping; full set and clear may hit different banks together.
  always_comb begin
    wr_en_c  = in_valid & in_ready;
    wr_cnt_d = wr_cnt_q;
    wb_d     = wb_q;
    full_d   = full_q;
    if (wr_en_c) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
      if (wr_cnt_q == LAST_POS) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end
    end
    if (rd_done_c) begin
      full_d[rd_bank] = 1'b0;
    end
    in_ready_d = ~full_d[wb_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      wb_q     <= 1'b0;
      full_q   <= 2'b00;
      in_ready <= 1'b1;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      wb_q     <= wb_d;
      full_q   <= full_d;
      in_ready <= in_ready_d;
    end
  end

  // Coefficient storage needs no reset: the full flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      bank_mem[wb_q][wr_cnt_q] <= in_data;
    end
  end

  assign rd_data_c = bank_mem[rd_bank][rd_addr_c];

  zz_rd_ctrl #(
    .W (W)
  ) u_rd_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .full       (full_q),
    .rd_data    (rd_data_c),
    .rd_bank    (rd_bank),
    .rd_addr_c  (rd_addr_c),
    .rd_done_c  (rd_done_c),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_first  (out_first),
    .out_last   (out_last),
    .out_blk_en (out_blk_en)
  );

endmodule

// File: tb/tb_zigzag_reorder.sv
// Bench for zigzag_reorder: queue-based reference model with the zig-zag
// order derived from a diagonal walk of the 8x8 block.
module tb_zigzag_reorder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic         out_first;
  logic         out_last;
  logic         out_blk_en;

  always #5 clk = ~clk;

  zigzag_reorder #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .out_first  (out_first),
    .out_last   (out_last),
    .out_blk_en (out_blk_en)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accepts = 0;
  int beats = 0;
  int out_pos = 0;
  int low_run = 0;
  int lat_at = -10;
  int rdy_mode = 1;
  bit lat_arm = 1'b0;
  bit gap_chk = 1'b0;
  bit seen_burst = 1'b0;
  logic [W-1:0] first_val, last_val;
  logic [W-1:0] src_q[$];
  logic [W-1:0] blk_q[$];
  logic [W-1:0] exp_q[$];
  int zz_order[64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Zig-zag scan: walk anti-diagonals r+c=s, alternating direction.
  task automatic build_zz();
    int n;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_order[n] = r * 8 + (s - r); n++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_order[n] = r * 8 + (s - r); n++; end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cyc == lat_at + 1) chk("latency_pre", 32'(out_valid), 32'd0);
    if (cyc == lat_at + 2) chk("latency", 32'(out_valid), 32'd1);
    if (out_blk_en) begin
      if (gap_chk && seen_burst && low_run > 0) chk("gap_len", 32'(low_run), 32'd1);
      low_run = 0;
      seen_burst = 1'b1;
    end else if (seen_burst) begin
      low_run++;
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        chk("data", 32'(out_data), 32'(exp_q[0]));
        chk("first", 32'(out_first), 32'(out_pos == 0));
        chk("last", 32'(out_last), 32'(out_pos == 63));
        chk("blk_en", 32'(out_blk_en), 32'd1);
      end
    end
    in_valid = (src_q.size() > 0);
    in_data  = in_valid ? src_q[0] : '0;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      2:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (in_valid && in_ready) begin
      blk_q.push_back(src_q.pop_front());
      accepts++;
      if (blk_q.size() == 64) begin
        for (int p = 0; p < 64; p++) exp_q.push_back(blk_q[zz_order[p]]);
        blk_q.delete();
        if (lat_arm) begin lat_at = cyc; lat_arm = 1'b0; end
      end
    end
    if (out_valid && out_ready && exp_q.size() > 0) begin
      if (out_pos == 0)  first_val = out_data;
      if (out_pos == 63) last_val = out_data;
      void'(exp_q.pop_front());
      out_pos = (out_pos + 1) % 64;
      beats++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (src_q.size() == 0 && exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    chk("drain_done", 32'(src_q.size() + exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_first", 32'(out_first), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_blk_en", 32'(out_blk_en), 32'd0);
    src_q.delete(); blk_q.delete(); exp_q.delete();
    out_pos = 0; low_run = 0; seen_burst = 1'b0;
    accepts = 0; beats = 0; lat_arm = 1'b0; lat_at = -10;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(W'($urandom));
  endtask

  task automatic push_ramp();
    for (int i = 0; i < 64; i++) src_q.push_back(W'(i));
  endtask

  initial begin
    build_zz();

    // Raster ramp with first-output latency.
    do_reset();
    rdy_mode = 1;
    lat_arm = 1'b1;
    push_ramp();
    drain();
    chk("ramp_beats", 32'(beats), 32'd64);
    chk("ramp_first_val", 32'(first_val), 32'd0);
    chk("ramp_last_val", 32'(last_val), 32'd63);

    // Three back-to-back blocks with continuous input.
    do_reset();
    rdy_mode = 1;
    gap_chk = 1'b1;
    push_rand(192);
    drain();
    gap_chk = 1'b0;
    chk("b2b_beats", 32'(beats), 32'd192);

    // Backpressure: two banks fill, then input stalls.
    do_reset();
    rdy_mode = 0;
    push_rand(200);
    repeat (150) tick();
    chk("bp_accepts", 32'(accepts), 32'd128);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_no_out", 32'(beats), 32'd0);
    rdy_mode = 1;
    drain();
    chk("bp_accepts_all", 32'(accepts), 32'd200);
    chk("bp_beats", 32'(beats), 32'd192);

    // Alternating out_ready.
    do_reset();
    rdy_mode = 2;
    push_rand(128);
    drain();
    chk("toggle_beats", 32'(beats), 32'd128);

    // Random out_ready.
    do_reset();
    rdy_mode = 3;
    push_rand(256);
    drain();
    chk("rand_beats", 32'(beats), 32'd256);

    // Reset in the middle of a burst and a partial block.
    do_reset();
    rdy_mode = 1;
    push_rand(94);
    for (int i = 0; i < 400 && accepts < 94; i++) tick();
    chk("mid_accepts", 32'(accepts), 32'd94);
    do_reset();
    lat_arm = 1'b1;
    push_ramp();
    drain();
    chk("post_rst_beats", 32'(beats), 32'd64);
    chk("post_rst_first", 32'(first_val), 32'd0);
    chk("post_rst_last", 32'(last_val), 32'd63);

    // Signed extremes at the DC and last positions.
    do_reset();
    rdy_mode = 3;
    src_q.push_back(8'h80);
    push_rand(62);
    src_q.push_back(8'h7f);
    drain();
    chk("signed_first", 32'(first_val), 32'h80);
    chk("signed_last", 32'(last_val), 32'h7f);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
